// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: FSM state
// encoding, RV32I opcode/funct3 constants and ALU operation codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_SLTU = 3'b011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

endpackage

// File: rtl/control_fsm_if.sv
// Control bundle between the control unit and the datapath/memories.
// master = control unit (consumes instr/Zero, drives control lines),
// slave  = datapath side.
interface control_fsm_if;
  logic [31:0] instr;
  logic        Zero;
  logic        PCSrc;
  logic        ALUSrc;
  logic        RegWrite;
  logic        MemToReg;
  logic        loadPC;
  logic        MemRead;
  logic        MemWrite;
  logic [3:0]  ALUCtrl;

  modport master (
    input  instr, Zero,
    output PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, ALUCtrl
  );

  modport slave (
    output instr, Zero,
    input  PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, ALUCtrl
  );
endinterface

// File: rtl/alu_decoder.sv
// Purely combinational instruction decode: classifies the instruction
// and picks the ALU operation. Anything unrecognised falls out as ADD
// with every class flag low, so it behaves as a NOP downstream.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [3:0] o_aluCtrl,
  output logic       o_isRType,
  output logic       o_isIType,
  output logic       o_isLw,
  output logic       o_isSw,
  output logic       o_isBeq
);

  logic [3:0] w_arithCtrl;

  // Instruction class flags; funct3 011 (SLTU) is not supported, so it is not a valid ALU op
  always_comb begin
    o_isRType = (i_opcode == OP_RTYPE)  && (i_funct3 != F3_SLTU);
    o_isIType = (i_opcode == OP_ITYPE)  && (i_funct3 != F3_SLTU);
    o_isLw    = (i_opcode == OP_LOAD)   && (i_funct3 == F3_WORD);
    o_isSw    = (i_opcode == OP_STORE)  && (i_funct3 == F3_WORD);
    o_isBeq   = (i_opcode == OP_BRANCH) && (i_funct3 == F3_BEQ);
  end

  // funct3/funct7[5] mapping shared by R-type and I-type; only R-type can select SUB
  always_comb begin
    w_arithCtrl = ALU_ADD;
    case (i_funct3)
      3'b000:  w_arithCtrl = (o_isRType && i_funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  w_arithCtrl = ALU_SLL;
      3'b010:  w_arithCtrl = ALU_SLT;
      3'b100:  w_arithCtrl = ALU_XOR;
      3'b101:  w_arithCtrl = i_funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_arithCtrl = ALU_OR;
      3'b111:  w_arithCtrl = ALU_AND;
      default: w_arithCtrl = ALU_ADD;
    endcase
  end

  // Final ALU code: memory ops add for the address, BEQ subtracts to compare
  always_comb begin
    o_aluCtrl = ALU_ADD;
    if (o_isRType || o_isIType) begin
      o_aluCtrl = w_arithCtrl;
    end else if (o_isBeq) begin
      o_aluCtrl = ALU_SUB;
    end
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control unit: sequences each instruction through
// IF -> ID -> EX -> MEM -> WB and drives the datapath control lines.
// Decode-derived outputs are combinational from instr; strobes are
// combinational from state so an async reset drops them at once.
module control_fsm
  import ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  control_fsm_if.master bus
);

  state_t     r_state;
  state_t     w_nextState;
  logic       r_brTaken;
  logic [3:0] w_aluCtrl;
  logic       w_isRType;
  logic       w_isIType;
  logic       w_isLw;
  logic       w_isSw;
  logic       w_isBeq;
  logic       w_unusedInstrBits;

  assign w_unusedInstrBits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  alu_decoder u_decoder (
    .i_opcode   (bus.instr[6:0]),
    .i_funct3   (bus.instr[14:12]),
    .i_funct7b5 (bus.instr[30]),
    .o_aluCtrl  (w_aluCtrl),
    .o_isRType  (w_isRType),
    .o_isIType  (w_isIType),
    .o_isLw     (w_isLw),
    .o_isSw     (w_isSw),
    .o_isBeq    (w_isBeq)
  );

  // State register; reset aborts any instruction and restarts at fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Fixed five-step sequence, no state is ever skipped
  always_comb begin
    w_nextState = S_IF;
    case (r_state)
      S_IF:    w_nextState = S_ID;
      S_ID:    w_nextState = S_EX;
      S_EX:    w_nextState = S_MEM;
      S_MEM:   w_nextState = S_WB;
      S_WB:    w_nextState = S_IF;
      default: w_nextState = S_IF;
    endcase
  end

  // Branch outcome is latched on leaving EX so Zero is ignored in every other cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_brTaken <= 1'b0;
    end else if (r_state == S_EX) begin
      r_brTaken <= w_isBeq & bus.Zero;
    end
  end

  // Steady decode outputs plus the one-cycle strobes keyed off state
  always_comb begin
    bus.ALUSrc   = w_isIType | w_isLw | w_isSw;
    bus.MemToReg = w_isLw;
    bus.ALUCtrl  = w_aluCtrl;
    bus.MemRead  = (r_state == S_MEM) && w_isLw;
    bus.MemWrite = (r_state == S_MEM) && w_isSw;
    bus.RegWrite = (r_state == S_WB) && (w_isRType | w_isIType | w_isLw);
    bus.loadPC   = (r_state == S_WB);
    bus.PCSrc    = (r_state == S_WB) && r_brTaken;
  end

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: a table of directed instructions,
// randomized instructions checked against a behavioural decode model,
// and reset-abort sequences in the middle of an instruction.
module tb_control_fsm;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  control_fsm_if bus ();

  control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] aluCtrl;
    logic       aluSrc;
    logic       memToReg;
    logic       writesReg;
    logic       readsMem;
    logic       writesMem;
    logic       isBranch;
  } refDecode_t;

  typedef struct {
    logic [31:0] ins;
    logic        zeroEx;
    logic        zeroOther;
    refDecode_t  exp;
    logic        pcSrc;
  } vector_t;

  vector_t vecs [13];

  // Behavioural decode straight from the ISA rules, using raw encodings
  function automatic refDecode_t refDecode(input logic [31:0] ins);
    refDecode_t d;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       alt;
    opc = ins[6:0];
    f3  = ins[14:12];
    alt = ins[30];
    d = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    if ((opc == 7'h33 || opc == 7'h13) && f3 != 3'd3) begin
      d.writesReg = 1'b1;
      d.aluSrc    = (opc == 7'h13);
      case (f3)
        3'd0: d.aluCtrl = (opc == 7'h33 && alt) ? 4'b0110 : 4'b0010;
        3'd1: d.aluCtrl = 4'b1001;
        3'd2: d.aluCtrl = 4'b0111;
        3'd4: d.aluCtrl = 4'b0101;
        3'd5: d.aluCtrl = alt ? 4'b1010 : 4'b1000;
        3'd6: d.aluCtrl = 4'b0001;
        default: d.aluCtrl = 4'b0000;
      endcase
    end else if (opc == 7'h03 && f3 == 3'd2) begin
      d.aluSrc = 1'b1; d.memToReg = 1'b1; d.writesReg = 1'b1; d.readsMem = 1'b1;
    end else if (opc == 7'h23 && f3 == 3'd2) begin
      d.aluSrc = 1'b1; d.writesMem = 1'b1;
    end else if (opc == 7'h63 && f3 == 3'd0) begin
      d.aluCtrl = 4'b0110; d.isBranch = 1'b1;
    end
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Runs cycles 1..nCycles of one instruction starting in IF; returns
  // positioned in the following IF after a full 5-cycle run, otherwise
  // still inside cycle nCycles
  task automatic applyStimulus(input logic [31:0] ins, input logic zeroEx, input logic zeroOther,
                               input int nCycles, input refDecode_t exp, input logic expPcSrc);
    for (int k = 1; k <= nCycles; k++) begin
      bus.instr = ins;
      bus.Zero  = (k == 3) ? zeroEx : zeroOther;
      #2;
      checkOutput($sformatf("%h c%0d ALUCtrl", ins, k),  bus.ALUCtrl,  exp.aluCtrl);
      checkOutput($sformatf("%h c%0d ALUSrc", ins, k),   bus.ALUSrc,   exp.aluSrc);
      checkOutput($sformatf("%h c%0d MemToReg", ins, k), bus.MemToReg, exp.memToReg);
      checkOutput($sformatf("%h c%0d MemRead", ins, k),  bus.MemRead,  (k == 4) && exp.readsMem);
      checkOutput($sformatf("%h c%0d MemWrite", ins, k), bus.MemWrite, (k == 4) && exp.writesMem);
      checkOutput($sformatf("%h c%0d RegWrite", ins, k), bus.RegWrite, (k == 5) && exp.writesReg);
      checkOutput($sformatf("%h c%0d loadPC", ins, k),   bus.loadPC,   k == 5);
      checkOutput($sformatf("%h c%0d PCSrc", ins, k),    bus.PCSrc,    (k == 5) && expPcSrc);
      if (k < nCycles || nCycles == 5) @(negedge clk);
    end
  endtask

  initial begin
    logic [6:0]  opcPool [7];
    logic [31:0] ins;
    logic        zEx;
    logic        zOther;
    refDecode_t  exp;

    vecs[0]  = '{32'h002081B3, 1'b1, 1'b1, '{4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b0};
    vecs[1]  = '{32'h0080A283, 1'b0, 1'b0, '{4'h2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}, 1'b0};
    vecs[2]  = '{32'h0050A623, 1'b1, 1'b0, '{4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b0};
    vecs[3]  = '{32'h00208863, 1'b1, 1'b0, '{4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b1};
    vecs[4]  = '{32'h00208863, 1'b0, 1'b1, '{4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b0};
    vecs[5]  = '{32'h4030D213, 1'b1, 1'b1, '{4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b0};
    vecs[6]  = '{32'h0000007F, 1'b1, 1'b1, '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0};
    vecs[7]  = '{32'h40208133, 1'b0, 1'b0, '{4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b0};
    vecs[8]  = '{32'h0000B283, 1'b1, 1'b0, '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0};
    vecs[9]  = '{32'h0020E1B3, 1'b0, 1'b1, '{4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b0};
    vecs[10] = '{32'h40008093, 1'b1, 1'b0, '{4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b0};
    vecs[11] = '{32'h0020D1B3, 1'b0, 1'b0, '{4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b0};
    vecs[12] = '{32'h0050A113, 1'b1, 1'b1, '{4'h7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b0};

    opcPool[0] = 7'h33; opcPool[1] = 7'h13; opcPool[2] = 7'h03; opcPool[3] = 7'h23;
    opcPool[4] = 7'h63; opcPool[5] = 7'h7F; opcPool[6] = 7'h37;

    // Reset: strobes must stay low even with a load on the bus
    rst       = 1'b1;
    bus.instr = 32'h0080A283;
    bus.Zero  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    checkOutput("reset MemRead",  bus.MemRead,  1'b0);
    checkOutput("reset RegWrite", bus.RegWrite, 1'b0);
    checkOutput("reset loadPC",   bus.loadPC,   1'b0);
    checkOutput("reset PCSrc",    bus.PCSrc,    1'b0);
    checkOutput("reset MemToReg follows instr", bus.MemToReg, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post-reset state", dut.r_state, S_IF);
    checkOutput("post-reset brTaken", dut.r_brTaken, 1'b0);

    // Directed table
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].ins, vecs[i].zeroEx, vecs[i].zeroOther, 5, vecs[i].exp, vecs[i].pcSrc);
    end

    // Randomized instructions against the behavioural model
    for (int i = 0; i < 60; i++) begin
      ins      = $urandom;
      ins[6:0] = opcPool[$urandom_range(0, 6)];
      zEx      = 1'($urandom_range(0, 1));
      zOther   = 1'($urandom_range(0, 1));
      exp      = refDecode(ins);
      applyStimulus(ins, zEx, zOther, 5, exp, exp.isBranch & zEx);
    end

    // Reset in MEM of a store: write strobe must drop without waiting for a clock
    applyStimulus(32'h0050A623, 1'b0, 1'b0, 4, refDecode(32'h0050A623), 1'b0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("sw reset MemWrite drops", bus.MemWrite, 1'b0);
    checkOutput("sw reset state", dut.r_state, S_IF);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("sw release state", dut.r_state, S_IF);

    // Reset in MEM of a taken branch: latched decision must be cleared
    applyStimulus(32'h00208863, 1'b1, 1'b0, 4, refDecode(32'h00208863), 1'b1);
    checkOutput("beq MEM brTaken", dut.r_brTaken, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("beq reset brTaken", dut.r_brTaken, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("beq release state", dut.r_state, S_IF);
    checkOutput("beq release brTaken", dut.r_brTaken, 1'b0);

    // Normal operation resumes cleanly after the abort
    applyStimulus(32'h002081B3, 1'b1, 1'b1, 5, refDecode(32'h002081B3), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
